// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the main-memory initiator: sizing constants, the
// controller state encoding and the request range/length helpers.
package mem_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 16384;
    localparam int MAX_BURST = 8;
    localparam int LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        RD_RSP,
        WR,
        WR_RSP,
        ERR_RSP
    } ctrl_state_t;

    // A zero length means a single word; anything above MAX_BURST is clamped.
    function automatic logic [LEN_W-1:0] effective_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return LEN_W'(1);
        end
        if (len > LEN_W'(MAX_BURST)) begin
            return LEN_W'(MAX_BURST);
        end
        return len;
    endfunction

    // The last touched word is checked in ADDR_W+1 bits so a burst can never
    // wrap past the top of the address space and look legal.
    function automatic logic in_range(
        input logic              is_write,
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  len
    );
        logic [ADDR_W:0] last_addr;
        last_addr = {1'b0, addr};
        if (!is_write) begin
            last_addr = last_addr + (ADDR_W+1)'(len) - (ADDR_W+1)'(1);
        end
        return last_addr < (ADDR_W+1)'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/mem_master_ctrl.sv
// Main-memory initiator: turns valid/ready load/store requests into registered
// memory accesses and returns one response beat per word (or one ack/error).
module mem_master_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

    ctrl_state_t       r_state;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mbr;
    logic [DATA_W-1:0] r_data_in;
    logic [LEN_W-1:0]  r_beats;
    logic              r_we;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic              r_rsp_err;

    logic [LEN_W-1:0]  w_eff_len;
    logic              w_legal;
    logic              w_accept;
    logic              w_rsp_hs;

    assign w_eff_len = effective_len(req_len);
    assign w_legal   = in_range(req_write, req_addr, w_eff_len);
    // Ready is held low while reset is asserted so nothing is accepted then.
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mar       <= '0;
            r_mbr       <= '0;
            r_data_in   <= '0;
            r_beats     <= '0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_mbr       <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= ERR_RSP;
                        end else if (req_write) begin
                            r_mar     <= req_addr;
                            r_data_in <= req_wdata;
                            r_we      <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_mar   <= req_addr;
                            r_beats <= w_eff_len;
                            r_state <= RD_ADDR;
                        end
                    end
                end

                // Memory samples the address on this edge; its data appears after it.
                RD_ADDR: begin
                    r_state <= RD_CAP;
                end

                RD_CAP: begin
                    r_mbr       <= mem_data_out;
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= (r_beats == LEN_W'(1));
                    r_state     <= RD_RSP;
                end

                RD_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        if (r_beats > LEN_W'(1)) begin
                            r_mar   <= r_mar + ADDR_W'(1);
                            r_beats <= r_beats - LEN_W'(1);
                            r_state <= RD_ADDR;
                        end else begin
                            r_beats <= '0;
                            r_state <= IDLE;
                        end
                    end
                end

                WR: begin
                    r_we        <= 1'b0;
                    r_mbr       <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= 1'b1;
                    r_state     <= WR_RSP;
                end

                WR_RSP, ERR_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr         = r_mar;
    assign mem_data_in      = r_data_in;
    assign mem_write_enable = r_we;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_mbr;
    assign rsp_last         = r_rsp_last;
    assign rsp_err          = r_rsp_err;

endmodule

// File: tb/tb_mem_master_ctrl.sv
// Randomized bench for mem_master_ctrl with an attached registered-read memory
// and a word-level reference model of expected responses and memory contents.
module tb_mem_master_ctrl;
    import mem_ctrl_pkg::*;

    localparam int IW = $clog2(MEM_DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_out;

    always #5 clk = ~clk;

    mem_master_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_len          (req_len),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_last         (rsp_last),
        .rsp_err          (rsp_err),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    // Attached memory: synchronous write, registered read.
    logic [DATA_W-1:0] sim_mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] ref_mem [0:MEM_DEPTH-1];

    always @(posedge clk) begin
        if (mem_write_enable) sim_mem[mem_addr[IW-1:0]] <= mem_data_in;
        mem_data_out <= sim_mem[mem_addr[IW-1:0]];
    end

    int                we_cnt = 0;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;

    always @(negedge clk) begin
        if (mem_write_enable) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
            we_data = mem_data_in;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;
    int exp_mar = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bit bad;
        int we0;
        int gap;
        bad = (int'(addr) >= MEM_DEPTH);
        wait_idle();
        we0 = we_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_len   = 4'($urandom_range(0, 15));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        gap = 0;
        while (!rsp_valid && gap < 20) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("st_gap",   32'(gap), bad ? 32'd0 : 32'd1);
        chk("st_last",  32'(rsp_last), 32'd1);
        chk("st_err",   32'(rsp_err), 32'(bad));
        chk("st_rdata", 32'(rsp_rdata), 32'd0);
        if (!bad) begin
            chk("st_mar",     32'(mem_addr), 32'(addr));
            chk("st_we_addr", 32'(we_addr), 32'(addr));
            chk("st_we_data", 32'(we_data), 32'(data));
            exp_mar = int'(addr);
            ref_mem[addr[IW-1:0]] = data;
        end else begin
            chk("st_err_mar", 32'(mem_addr), 32'(exp_mar));
        end
        chk("st_we_cnt", 32'(we_cnt - we0), bad ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        chk("st_done", 32'(rsp_valid), 32'd0);
        $display("store addr=%h data=%h err=%0b", addr, data, bad);
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len, input int stall);
        int n;
        int beats;
        int gap;
        int we0;
        bit bad;
        logic [DATA_W-1:0] expd;
        logic [ADDR_W-1:0] expa;
        n     = (len == 0) ? 1 : ((int'(len) > MAX_BURST) ? MAX_BURST : int'(len));
        bad   = (int'(addr) + n - 1 >= MEM_DEPTH);
        beats = bad ? 1 : n;
        wait_idle();
        we0 = we_cnt;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = len;
        req_wdata = 16'($urandom);
        rsp_ready = (stall > 0) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            gap = 0;
            if (b > 0) begin
                @(posedge clk); #1;
                gap = 1;
            end
            while (!rsp_valid && gap < 20) begin
                @(posedge clk); #1;
                gap++;
            end
            chk("ld_gap", 32'(gap), (b == 0) ? (bad ? 32'd0 : 32'd2) : 32'd3);
            if (gap >= 20) return;
            expd = bad ? '0 : ref_mem[(int'(addr) + b) % MEM_DEPTH];
            expa = bad ? ADDR_W'(exp_mar) : ADDR_W'(int'(addr) + b);
            chk("ld_rdata", 32'(rsp_rdata), 32'(expd));
            chk("ld_last",  32'(rsp_last), 32'(b == beats - 1));
            chk("ld_err",   32'(rsp_err), 32'(bad));
            chk("ld_mar",   32'(mem_addr), 32'(expa));
            if (b == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    chk("bp_valid",     32'(rsp_valid), 32'd1);
                    chk("bp_rdata",     32'(rsp_rdata), 32'(expd));
                    chk("bp_mar",       32'(mem_addr), 32'(expa));
                    chk("bp_req_ready", 32'(req_ready), 32'd0);
                end
                rsp_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk("ld_done",   32'(rsp_valid), 32'd0);
        chk("ld_we_cnt", 32'(we_cnt - we0), 32'd0);
        if (!bad) exp_mar = int'(addr) + beats - 1;
        $display("load  addr=%h len=%0d beats=%0d stall=%0d err=%0b", addr, len, beats, stall, bad);
    endtask

    task automatic reset_mid_store(input logic [ADDR_W-1:0] addr);
        int we0;
        wait_idle();
        we0 = we_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = ~ref_mem[addr[IW-1:0]];
        req_len   = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rs_we_before", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("rs_we_async",  32'(mem_write_enable), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_ready_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_mar = 0;
        #1;
        chk("rs_ready",  32'(req_ready), 32'd1);
        chk("rs_mar",    32'(mem_addr), 32'(exp_mar));
        chk("rs_mem",    32'(sim_mem[addr[IW-1:0]]), 32'(ref_mem[addr[IW-1:0]]));
        chk("rs_we_cnt", 32'(we_cnt - we0), 32'd0);
        $display("reset during store addr=%h", addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] v;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            v = 16'($urandom);
            sim_mem[i] = v;
            ref_mem[i] = v;
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_we",        32'(mem_write_enable), 32'd0);
        chk("rst_mar",       32'(mem_addr), 32'd0);
        chk("rst_rdata",     32'(rsp_rdata), 32'd0);
        chk("rst_flags",     32'({rsp_last, rsp_err}), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        do_store(16'h0010, 16'h1234);
        do_load(16'h0010, 4'd1, 0);
        for (int i = 0; i < 4; i++) do_store(ADDR_W'(16'h0100 + i), DATA_W'(16'h00A0 + i));
        do_load(16'h0100, 4'd4, 0);
        do_load(16'h0100, 4'd2, 5);
        do_load(16'h3FFF, 4'd2, 0);
        do_store(16'h4000, 16'hBEEF);
        do_load(16'h3FFF, 4'd1, 0);
        do_load(16'h0200, 4'd0, 0);
        do_load(16'h0300, 4'd15, 0);
        do_load(16'h3FF8, 4'd9, 1);
        do_load(16'hFFFF, 4'd1, 0);
        reset_mid_store(16'h0020);
        do_load(16'h0020, 4'd1, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(MEM_DEPTH - 10, MEM_DEPTH + 3));
            else                           a = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
            if ($urandom_range(0, 1) == 0) do_store(a, 16'($urandom));
            else                           do_load(a, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
